lenet_frame_sched: RTL and testbench



---
 rtl/lenet_frame_sched_pkg.sv | 16 +
 rtl/lenet_frame_sched_if.sv | 47 ++++
 rtl/lenet_frame_sched.sv | 139 +++++++++++++
 tb/tb_lenet_frame_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_frame_sched_pkg.sv
// Shared types and constants for the LeNet frame scheduler.
package lenet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    INFER
  } sched_state_e;

  localparam int unsigned LENET_SIZE = 28;
  localparam int unsigned RESULT_W   = 4;

  typedef logic [RESULT_W-1:0] lenet_class_t;

endpackage

// File: rtl/lenet_frame_sched_if.sv
// Bundle between the frame scheduler (master) and the camera core / inference engine (slave).
interface lenet_frame_sched_if #(
  parameter int unsigned RESULT_W = 4,
  parameter int unsigned MISS_W   = 8
) ();

  logic                enable;
  logic                frame_start;
  logic                data_ready;
  logic                lenet_done;
  logic [RESULT_W-1:0] lenet_class;
  logic                lenet_signal;
  logic                lenet_start;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic                busy;
  logic [MISS_W-1:0]   miss_count;

  modport master (
    input  enable,
    input  frame_start,
    input  data_ready,
    input  lenet_done,
    input  lenet_class,
    output lenet_signal,
    output lenet_start,
    output result,
    output result_valid,
    output busy,
    output miss_count
  );

  modport slave (
    output enable,
    output frame_start,
    output data_ready,
    output lenet_done,
    output lenet_class,
    input  lenet_signal,
    input  lenet_start,
    input  result,
    input  result_valid,
    input  busy,
    input  miss_count
  );

endinterface

// File: rtl/lenet_frame_sched.sv
// Per-frame capture/inference controller. Optional inference watchdog enabled by
// defining LENET_SCHED_TIMEOUT_EN.
module lenet_frame_sched #(
  parameter int unsigned SKIP_FRAMES    = 2,
  parameter int unsigned SKIP_W         = 4,
  parameter int unsigned RESULT_W       = lenet_pkg::RESULT_W,
  parameter int unsigned MISS_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                 clk25,
  input logic                 rst,
  lenet_frame_sched_if.master bus
);

  import lenet_pkg::*;

  localparam logic [SKIP_W-1:0] SkipInit = SKIP_W'(SKIP_FRAMES);

  sched_state_e        state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                lenet_signal_q, lenet_signal_d;
  logic                lenet_start_q, lenet_start_d;
  logic                result_valid_q, result_valid_d;
  logic                miss_evt;
  logic                timeout;

`ifdef LENET_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counter idles at zero outside INFER, so it is already clear on entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == INFER) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == INFER) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk25) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    skip_d         = skip_q;
    result_d       = result_q;
    lenet_signal_d = 1'b0;
    lenet_start_d  = 1'b0;
    result_valid_d = 1'b0;
    miss_evt       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.enable && (skip_q == '0)) begin
          state_d = ARM;
        end else if (bus.frame_start && (skip_q != '0)) begin
          skip_d = skip_q - 1'b1;
        end
      end
      ARM: begin
        // A frame_start means the core already latched the request, so it wins over enable.
        if (bus.frame_start) begin
          state_d = CAPTURE;
        end else if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          lenet_signal_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.data_ready) begin
          state_d       = INFER;
          lenet_start_d = 1'b1;
        end else if (bus.frame_start) begin
          miss_evt = 1'b1;
          state_d  = bus.enable ? ARM : IDLE;
        end
      end
      INFER: begin
        if (bus.lenet_done) begin
          result_d       = bus.lenet_class;
          result_valid_d = 1'b1;
          skip_d         = SkipInit;
          state_d        = IDLE;
        end else if (timeout) begin
          miss_evt = 1'b1;
          skip_d   = SkipInit;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    miss_d = miss_q;
    if (miss_evt && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q        <= IDLE;
      skip_q         <= '0;
      miss_q         <= '0;
      result_q       <= '0;
      lenet_signal_q <= 1'b0;
      lenet_start_q  <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      skip_q         <= skip_d;
      miss_q         <= miss_d;
      result_q       <= result_d;
      lenet_signal_q <= lenet_signal_d;
      lenet_start_q  <= lenet_start_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.lenet_signal = lenet_signal_q;
  assign bus.lenet_start  = lenet_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.miss_count   = miss_q;
  assign bus.busy         = (state_q == CAPTURE) || (state_q == INFER);

endmodule

// File: tb/tb_lenet_frame_sched.sv
// Directed bench: scoreboard for lenet_start/result_valid on a SKIP_FRAMES=0 instance,
// level checks on a SKIP_FRAMES=2 instance.
module tb_lenet_frame_sched;

  import lenet_pkg::*;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk25 = ~clk25;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  logic cyc_hold = 1'b1;
  logic b_done   = 1'b0;

  always @(posedge clk25) cyc <= cyc_hold ? 0 : cyc + 1;

  lenet_frame_sched_if #(.RESULT_W(4), .MISS_W(2)) bus_a ();
  lenet_frame_sched_if #(.RESULT_W(4), .MISS_W(8)) bus_b ();

  lenet_frame_sched #(
    .SKIP_FRAMES   (0),
    .SKIP_W        (4),
    .RESULT_W      (4),
    .MISS_W        (2),
    .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk25(clk25),
    .rst  (rst),
    .bus  (bus_a)
  );

  lenet_frame_sched #(
    .SKIP_FRAMES   (2),
    .SKIP_W        (4),
    .RESULT_W      (4),
    .MISS_W        (8),
    .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk25(clk25),
    .rst  (rst),
    .bus  (bus_b)
  );

  typedef struct {
    int cyc;
    int cls;
  } res_t;

  int   exp_start[$];
  res_t exp_res[$];
  res_t mon_r;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the edge that starts cycle n.
  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(posedge clk25);
      #1;
      guard++;
    end
    chk("cycle alignment", cyc, n);
  endtask

  always @(negedge clk25) begin
    if (bus_a.lenet_start) begin
      if (exp_start.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected lenet_start: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("lenet_start cycle", cyc, exp_start.pop_front());
      end
    end
    if (bus_a.result_valid) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected result_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_r = exp_res.pop_front();
        chk("result_valid cycle", cyc, mon_r.cyc);
        chk("result value", int'(bus_a.result), mon_r.cls);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // Skip-interval instance.
  initial begin
    bus_b.enable      = 1'b1;
    bus_b.frame_start = 1'b0;
    bus_b.data_ready  = 1'b0;
    bus_b.lenet_done  = 1'b0;
    bus_b.lenet_class = '0;
    wait (cyc_hold == 1'b0);
    goto(2);  chk("B lenet_signal armed", int'(bus_b.lenet_signal), 1);
    goto(5);  bus_b.frame_start = 1'b1;
    goto(6);  bus_b.frame_start = 1'b0;
    goto(8);  bus_b.data_ready = 1'b1;
    goto(9);  bus_b.data_ready = 1'b0;
    chk("B lenet_start", int'(bus_b.lenet_start), 1);
    goto(10); chk("B lenet_start one cycle", int'(bus_b.lenet_start), 0);
    goto(12); bus_b.lenet_done = 1'b1; bus_b.lenet_class = lenet_class_t'(4);
    goto(13); bus_b.lenet_done = 1'b0;
    chk("B result_valid", int'(bus_b.result_valid), 1);
    chk("B result", int'(bus_b.result), 4);
    chk("B busy after result", int'(bus_b.busy), 0);
    goto(14); chk("B result_valid one cycle", int'(bus_b.result_valid), 0);
    goto(16); bus_b.frame_start = 1'b1;
    goto(17); bus_b.frame_start = 1'b0;
    chk("B skip 1st frame", int'(bus_b.lenet_signal), 0);
    goto(20); bus_b.frame_start = 1'b1;
    goto(21); bus_b.frame_start = 1'b0;
    chk("B skip 2nd frame", int'(bus_b.lenet_signal), 0);
    goto(22); chk("B ARM entry", int'(bus_b.lenet_signal), 0);
    goto(23); chk("B re-armed", int'(bus_b.lenet_signal), 1);
    goto(30); bus_b.frame_start = 1'b1;
    goto(31); bus_b.frame_start = 1'b0;
    chk("B 3rd frame captured", int'(bus_b.busy), 1);
    chk("B signal drop in capture", int'(bus_b.lenet_signal), 0);
    b_done = 1'b1;
  end

  initial begin
    bus_a.enable      = 1'b1;
    bus_a.frame_start = 1'b0;
    bus_a.data_ready  = 1'b0;
    bus_a.lenet_done  = 1'b0;
    bus_a.lenet_class = '0;
    repeat (2) @(posedge clk25);
    #1;
    chk("reset lenet_signal", int'(bus_a.lenet_signal), 0);
    chk("reset lenet_start", int'(bus_a.lenet_start), 0);
    chk("reset result_valid", int'(bus_a.result_valid), 0);
    chk("reset busy", int'(bus_a.busy), 0);
    chk("reset result", int'(bus_a.result), 0);
    chk("reset miss_count", int'(bus_a.miss_count), 0);
    rst      = 1'b0;
    cyc_hold = 1'b0;

    // Basic capture.
    goto(1);   chk("signal low on ARM entry", int'(bus_a.lenet_signal), 0);
    goto(2);   chk("signal high cycle 2", int'(bus_a.lenet_signal), 1);
    goto(10);  chk("signal high cycle 10", int'(bus_a.lenet_signal), 1);
    bus_a.frame_start = 1'b1;
    goto(11);  bus_a.frame_start = 1'b0;
    chk("signal low in capture", int'(bus_a.lenet_signal), 0);
    chk("busy in capture", int'(bus_a.busy), 1);
    goto(40);  bus_a.data_ready = 1'b1; exp_start.push_back(41);
    goto(41);  bus_a.data_ready = 1'b0;
    chk("busy in infer", int'(bus_a.busy), 1);
    goto(100); bus_a.lenet_done = 1'b1; bus_a.lenet_class = lenet_class_t'(7);
    exp_res.push_back('{cyc: 101, cls: 7});
    goto(101); bus_a.lenet_done = 1'b0;
    chk("busy after done", int'(bus_a.busy), 0);
    chk("result level", int'(bus_a.result), 7);
    goto(103); chk("re-armed after result", int'(bus_a.lenet_signal), 1);

    // data_ready and frame_start together: no miss.
    goto(110); bus_a.frame_start = 1'b1;
    goto(111); bus_a.frame_start = 1'b0;
    goto(120); bus_a.data_ready = 1'b1; bus_a.frame_start = 1'b1; exp_start.push_back(121);
    goto(121); bus_a.data_ready = 1'b0; bus_a.frame_start = 1'b0;
    chk("no miss on tie", int'(bus_a.miss_count), 0);
    chk("infer after tie", int'(bus_a.busy), 1);
    goto(125); bus_a.lenet_done = 1'b1; bus_a.lenet_class = lenet_class_t'(3);
    exp_res.push_back('{cyc: 126, cls: 3});
    goto(126); bus_a.lenet_done = 1'b0;

    // Missed capture and saturation.
    goto(130); bus_a.frame_start = 1'b1;
    goto(131); bus_a.frame_start = 1'b0;
    goto(140); bus_a.frame_start = 1'b1;
    goto(141); bus_a.frame_start = 1'b0;
    chk("miss_count first miss", int'(bus_a.miss_count), 1);
    chk("ARM after miss", int'(bus_a.busy), 0);
    goto(142); chk("signal after miss", int'(bus_a.lenet_signal), 1);
    for (int i = 0; i < 4; i++) begin
      goto(150 + 10 * i); bus_a.frame_start = 1'b1;
      goto(151 + 10 * i); bus_a.frame_start = 1'b0;
      goto(155 + 10 * i); bus_a.frame_start = 1'b1;
      goto(156 + 10 * i); bus_a.frame_start = 1'b0;
      chk("miss_count saturating", int'(bus_a.miss_count), (i + 2 > 3) ? 3 : i + 2);
    end

    // Enable drop in ARM, stray inputs in IDLE.
    goto(190); chk("signal before enable drop", int'(bus_a.lenet_signal), 1);
    bus_a.enable = 1'b0;
    goto(191); chk("signal after enable drop", int'(bus_a.lenet_signal), 0);
    chk("idle after enable drop", int'(bus_a.busy), 0);
    goto(195); bus_a.lenet_done = 1'b1; bus_a.lenet_class = lenet_class_t'(9);
    goto(196); bus_a.lenet_done = 1'b0;
    chk("stray done no valid", int'(bus_a.result_valid), 0);
    chk("stray done result kept", int'(bus_a.result), 3);
    goto(198); bus_a.data_ready = 1'b1;
    goto(199); bus_a.data_ready = 1'b0;
    goto(200); chk("stray data_ready no start", int'(bus_a.lenet_start), 0);
    chk("no arm while disabled", int'(bus_a.lenet_signal), 0);
    bus_a.enable = 1'b1;
    goto(202); chk("re-arm on enable", int'(bus_a.lenet_signal), 1);

    // Reset during INFER.
    goto(205); bus_a.frame_start = 1'b1;
    goto(206); bus_a.frame_start = 1'b0;
    goto(210); bus_a.data_ready = 1'b1; exp_start.push_back(211);
    goto(211); bus_a.data_ready = 1'b0;
    chk("infer before reset", int'(bus_a.busy), 1);
    goto(215); rst = 1'b1;
    goto(216); rst = 1'b0;
    chk("mid reset lenet_signal", int'(bus_a.lenet_signal), 0);
    chk("mid reset lenet_start", int'(bus_a.lenet_start), 0);
    chk("mid reset result_valid", int'(bus_a.result_valid), 0);
    chk("mid reset busy", int'(bus_a.busy), 0);
    chk("mid reset result", int'(bus_a.result), 0);
    chk("mid reset miss_count", int'(bus_a.miss_count), 0);
    goto(220); bus_a.lenet_done = 1'b1; bus_a.lenet_class = lenet_class_t'(5);
    goto(221); bus_a.lenet_done = 1'b0;
    chk("abandoned done no valid", int'(bus_a.result_valid), 0);
    chk("abandoned done result", int'(bus_a.result), 0);

`ifdef LENET_SCHED_TIMEOUT_EN
    goto(230); bus_a.frame_start = 1'b1;
    goto(231); bus_a.frame_start = 1'b0;
    goto(235); bus_a.data_ready = 1'b1; exp_start.push_back(236);
    goto(236); bus_a.data_ready = 1'b0;
    goto(251); chk("still infer before timeout", int'(bus_a.busy), 1);
    goto(252); chk("idle after timeout", int'(bus_a.busy), 0);
    chk("timeout miss_count", int'(bus_a.miss_count), 1);
    chk("timeout result unchanged", int'(bus_a.result), 0);
`endif

    goto(260);
    chk("skip instance finished", int'(b_done), 1);
    chk("lenet_start events outstanding", exp_start.size(), 0);
    chk("result events outstanding", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
